// File: rtl/cv32e40p_x_result_buf.sv
// Writeback buffer for eXtension-interface results: bypasses straight to the
// register file when the port is free, otherwise queues results in order.
module cv32e40p_x_result_buf #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   x_result_valid_i,
  output logic                   x_result_ready_o,
  input  logic [ID_WIDTH-1:0]    x_result_id_i,
  input  logic [XLEN-1:0]        x_result_data_i,
  input  logic [4:0]             x_result_rd_i,
  input  logic                   x_result_we_i,
  input  logic                   core_wb_we_i,
  input  logic [2:0][4:0]        rs_addr_i,
  output logic [2:0]             pend_hit_o,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [XLEN-1:0]        rf_wdata_o,
  output logic [ID_WIDTH-1:0]    rf_wid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]          rd_mem   [DEPTH];
  logic [XLEN-1:0]     data_mem [DEPTH];
  logic [ID_WIDTH-1:0] id_mem   [DEPTH];

  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;

  logic accept, writable, bypass, push, pop;

  assign empty_o          = (count_reg == '0);
  assign full_o           = (count_reg == CW'(DEPTH));
  assign count_o          = count_reg;
  assign x_result_ready_o = ~full_o & ~rst_i;

  assign accept   = x_result_valid_i & x_result_ready_o;
  assign writable = x_result_we_i & (x_result_rd_i != 5'd0);
  // Core WB always wins the port; bypass only when nothing older is queued.
  assign pop      = ~empty_o & ~core_wb_we_i & ~rst_i;
  assign bypass   = empty_o & ~core_wb_we_i & accept & writable;
  assign push     = accept & writable & ~bypass;

  always_comb begin
    rf_we_o    = pop | bypass;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rf_wid_o   = '0;
    if (!empty_o) begin
      rf_waddr_o = rd_mem[rd_ptr_reg];
      rf_wdata_o = data_mem[rd_ptr_reg];
      rf_wid_o   = id_mem[rd_ptr_reg];
    end else if (bypass) begin
      rf_waddr_o = x_result_rd_i;
      rf_wdata_o = x_result_data_i;
      rf_wid_o   = x_result_id_i;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    valid_next  = valid_reg;
    if (push) begin
      wr_ptr_next            = wr_ptr_reg + 1'b1;
      valid_next[wr_ptr_reg] = 1'b1;
    end
    if (pop) begin
      rd_ptr_next            = rd_ptr_reg + 1'b1;
      valid_next[rd_ptr_reg] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= x_result_rd_i;
      data_mem[wr_ptr_reg] <= x_result_data_i;
      id_mem[wr_ptr_reg]   <= x_result_id_i;
    end
  end

  // Hazard check looks only at stored entries, so a bypassing result never hits.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hit
      logic [DEPTH-1:0] match;
      for (gj = 0; gj < DEPTH; gj++) begin : g_ent
        assign match[gj] = valid_reg[gj] & (rd_mem[gj] == rs_addr_i[gi]);
      end
      assign pend_hit_o[gi] = ~rst_i & (rs_addr_i[gi] != 5'd0) & (|match);
    end
  endgenerate

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// Scoreboard bench: driver queues every writable accepted result, monitor
// checks RF writes, status and hazard hits against an in-order model.
module tb_cv32e40p_x_result_buf;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam int IDW   = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            x_result_valid_i = 1'b0;
  logic            x_result_ready_o;
  logic [IDW-1:0]  x_result_id_i = '0;
  logic [XLEN-1:0] x_result_data_i = '0;
  logic [4:0]      x_result_rd_i = '0;
  logic            x_result_we_i = 1'b0;
  logic            core_wb_we_i = 1'b0;
  logic [2:0][4:0] rs_addr_i = '0;
  logic [2:0]      pend_hit_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic [IDW-1:0]  rf_wid_o;
  logic [$clog2(DEPTH):0] count_o;
  logic            empty_o, full_o;

  always #5 clk = ~clk;

  cv32e40p_x_result_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_WIDTH(IDW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
    .core_wb_we_i(core_wb_we_i), .rs_addr_i(rs_addr_i), .pend_hit_o(pend_hit_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_wid_o(rf_wid_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [IDW-1:0]  id;
  } exp_t;

  exp_t q[$];        // writable accepted results not yet written, oldest first
  int   exp_count = 0; // how many of them sit in the buffer at cycle start
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic       m_we;
  logic [2:0] m_hit;
  exp_t       m_head;
  initial begin
    forever begin
      @(negedge clk);
      m_we  = !rst_i && !core_wb_we_i && (q.size() > 0);
      m_hit = '0;
      if (!rst_i)
        for (int k = 0; k < 3; k++)
          for (int i = 0; i < exp_count; i++)
            if (rs_addr_i[k] != 5'd0 && q[i].rd == rs_addr_i[k]) m_hit[k] = 1'b1;
      chk("ready", {31'd0, x_result_ready_o}, {31'd0, !rst_i && exp_count < DEPTH});
      chk("count", 32'(count_o), exp_count);
      chk("empty", {31'd0, empty_o}, {31'd0, exp_count == 0});
      chk("full", {31'd0, full_o}, {31'd0, exp_count == DEPTH});
      chk("rf_we", {31'd0, rf_we_o}, {31'd0, m_we});
      chk("pend_hit", 32'(pend_hit_o), 32'(m_hit));
      if (rf_we_o && m_we) begin
        m_head = q.pop_front();
        chk("rf_waddr", 32'(rf_waddr_o), 32'(m_head.rd));
        chk("rf_wdata", rf_wdata_o, m_head.data);
        chk("rf_wid", 32'(rf_wid_o), 32'(m_head.id));
        $display("write rd=%0d data=%08h id=%0d", rf_waddr_o, rf_wdata_o, rf_wid_o);
      end
      if (rst_i) begin
        q.delete();
        exp_count = 0;
      end else begin
        exp_count = q.size();
      end
    end
  end

  task automatic cycle(input logic rst, input logic cwe, input logic v, input logic we,
                       input logic [4:0] rd, input logic [31:0] data, input logic [3:0] id,
                       input logic [2:0][4:0] rs, output logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_i = rst; core_wb_we_i = cwe; x_result_valid_i = v; x_result_we_i = we;
    x_result_rd_i = rd; x_result_data_i = data; x_result_id_i = id; rs_addr_i = rs;
    #2;
    acc = v && x_result_ready_o && !rst;
    if (acc) begin
      $display("accept rd=%0d we=%0d data=%08h id=%0d core_we=%0d", rd, we, data, id, cwe);
      if (we && rd != 5'd0) begin
        e.rd = rd; e.data = data; e.id = id;
        q.push_back(e);
      end
    end
  endtask

  logic acc;
  logic ph;
  int   tries;
  logic [2:0][4:0] rs_r;

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, '0, acc);
    cycle(1, 0, 0, 0, 0, 0, 0, '0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    chk("reset_waddr", 32'(rf_waddr_o), 0);
    chk("reset_wdata", rf_wdata_o, 0);
    chk("reset_wid", 32'(rf_wid_o), 0);

    // Bypass
    cycle(0, 0, 1, 1, 5, 32'hDEADBEEF, 1, '0, acc);
    chk("bypass_accept", {31'd0, acc}, 1);
    // Blocked then drained
    cycle(0, 1, 1, 1, 3, 32'h33333333, 2, '0, acc);
    cycle(0, 1, 1, 1, 4, 32'h44444444, 3, '0, acc);
    cycle(0, 1, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd4}, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    // Simultaneous push/pop with same rd
    cycle(0, 1, 1, 1, 7, 32'hAAAA0007, 4, '0, acc);
    cycle(0, 0, 1, 1, 7, 32'hBBBB0007, 5, {5'd0, 5'd0, 5'd7}, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    // Dropped results
    cycle(0, 0, 1, 0, 9, 32'h99999999, 6, '0, acc);
    chk("drop_we0_accept", {31'd0, acc}, 1);
    cycle(0, 0, 1, 1, 0, 32'h00000001, 7, '0, acc);
    chk("drop_rd0_accept", {31'd0, acc}, 1);
    cycle(0, 1, 1, 1, 0, 32'h00000002, 8, '0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    // Pointer wrap: 10 results, core WB alternating
    ph = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        cycle(0, ph, 1, 1, 5'(i + 1), $urandom, 4'(i), '0, acc);
        ph = ~ph;
        tries++;
      end while (!acc && tries < 20);
      if (!acc) chk("wrap_accept_timeout", 0, 1);
    end
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    // Reset mid-operation
    cycle(0, 1, 1, 1, 10, 32'h1010_1010, 9, '0, acc);
    cycle(0, 1, 1, 1, 11, 32'h1111_1111, 10, '0, acc);
    cycle(1, 0, 0, 0, 0, 0, 0, {5'd0, 5'd11, 5'd10}, acc);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd11, 5'd10}, acc);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) rs_r[k] = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 7)), $urandom, 4'($urandom), rs_r, acc);
    end
    repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, '0, acc);
    repeat (2) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_buf.md
# cv32e40p_x_result_buf

Writeback buffer between the eXtension-interface result channel and the core register-file write port. It accepts coprocessor results (`x_result_*`) and writes them into the GPR file on cycles when the core's own WB stage does not use the port. When the port is busy, results are held in an in-order FIFO. It reports buffered destination registers so the dispatcher can hold dependent instructions, and its register-file write pulse is the dispatcher's scoreboard-clear event.

## Interface
Parameters:
- `DEPTH`, 2, FIFO entries; power of two, ≥2
- `XLEN`, 32, data width
- `ID_WIDTH`, 4, instruction ID width (matches issue/commit ID)

Ports:
- `clk_i` input 1 — clock, rising edge
- `rst_i` input 1 — synchronous, active-high reset
- `x_result_valid_i` input 1 — coprocessor result valid
- `x_result_ready_o` output 1 — buffer can accept a result
- `x_result_id_i` input ID_WIDTH — result ID; carried through, not checked
- `x_result_data_i` input XLEN — result data
- `x_result_rd_i` input 5 — destination register
- `x_result_we_i` input 1 — result writes `rd`
- `core_wb_we_i` input 1 — core WB stage owns the RF write port this cycle
- `rs_addr_i` input 3×5 — source registers of the instruction in ID
- `pend_hit_o` output 3 — `rs_addr_i[k]` matches a buffered `rd`
- `rf_we_o` output 1 — RF write enable; also the scoreboard clear strobe
- `rf_waddr_o` output 5 — RF write address
- `rf_wdata_o` output XLEN — RF write data
- `rf_wid_o` output ID_WIDTH — ID of the result being written
- `count_o` output $clog2(DEPTH)+1 — number of occupied entries
- `empty_o`, `full_o` output 1 — FIFO status

## Operation
- **Accept.** A handshake is `x_result_valid_i & x_result_ready_o`.
- **Ready.** `x_result_ready_o = ~full_o & ~rst_i`. Ready does not depend on a same-cycle pop.
- **Dropped results.** An accepted result with `we=0`, or with `rd=0`, is consumed and discarded. It is never stored or written.
- **Storage.** The FIFO uses read/write pointers of width $clog2(DEPTH) that wrap modulo DEPTH. Each entry holds {rd, data, id}.
- **Port arbitration.** The core always has priority. The buffer drives the RF only when `core_wb_we_i=0`.
- **Bypass.** The result is written directly in the same cycle, without storage, when all of these hold:
  - the FIFO is empty;
  - `core_wb_we_i=0`;
  - an accepted result has `we=1` and `rd≠0`.
- **Drain.** When the FIFO is not empty and `core_wb_we_i=0`, the head entry drives `rf_*` with `rf_we_o=1` and is popped at the clock edge.
  - Bypass is disabled whenever the FIFO is not empty, which preserves write order.
- **Push.** An accepted, writable result that is not bypassed is pushed at the edge.
- **Count update.**
  - Simultaneous push and pop: `count` is unchanged and both pointers advance.
  - Push only: +1.
  - Pop only: −1.
  - `count` never exceeds DEPTH and never goes below 0.
- **Pending hit.** `pend_hit_o[k] = (rs_addr_i[k]≠0) & OR over valid entries of (entry.rd == rs_addr_i[k])`.
  - The check is purely combinational on stored entries.
  - A result being bypassed in the current cycle does not produce a hit.
- **Idle outputs.** When `rf_we_o=0`, `rf_waddr_o`, `rf_wdata_o` and `rf_wid_o` show the head entry (don't-care when empty).
- **Reset.**
  - While `rst_i=1`: `rf_we_o=0`, `x_result_ready_o=0`, `pend_hit_o=0`.
  - At the edge: pointers=0, count=0, all entry valid bits=0.
  - Reset mid-operation discards all buffered results. Clearing the scoreboard is the dispatcher's responsibility.
- **Reset values of outputs after reset:**
  - `count_o=0`, `empty_o=1`, `full_o=0`;
  - `x_result_ready_o=1` once `rst_i` deasserts;
  - `rf_we_o=0`, `rf_waddr_o=0`, `rf_wdata_o=0`, `rf_wid_o=0`;
  - `pend_hit_o=0`.

## Timing
- **Bypass latency:** 0 cycles. The RF is written at the same edge the result is accepted.
- **Buffered latency:** a pushed result is written no earlier than the cycle after acceptance.
  - Each cycle with `core_wb_we_i=1` adds one cycle of delay.
- **Throughput:** one accept and one RF write per cycle.
- **Full FIFO:** `ready=0`. A pop in that cycle frees space, and ready rises in the next cycle.
- **Starvation:** if `core_wb_we_i` stays high indefinitely, the FIFO fills and backpressures the coprocessor. No result is lost.
- **Combinational paths:**
  - from `core_wb_we_i`, `x_result_*` to `rf_*`;
  - from `rs_addr_i` to `pend_hit_o`;
  - no path from `x_result_valid_i` to `x_result_ready_o`.

## Test plan
- **Bypass.** Empty FIFO, `core_wb_we_i=0`, result rd=5, data=0xDEADBEEF, we=1 → in the same cycle `rf_we_o=1`, `rf_waddr_o=5`, `rf_wdata_o=0xDEADBEEF`; `count_o` stays 0.
- **Blocked then drained.** `core_wb_we_i=1` for 3 cycles while results rd=3 then rd=4 arrive (DEPTH=2):
  - `full_o=1` and ready=0 after the second push;
  - `pend_hit_o[0]=1` for `rs_addr_i[0]=4`;
  - after `core_wb_we_i` drops, rd=3 is written, then rd=4 on the following cycle, then `empty_o=1`.
- **Simultaneous push/pop.** count=1 with head rd=7, new result rd=7 accepted, `core_wb_we_i=0`:
  - old rd=7 data is written this cycle;
  - count stays 1;
  - the new data is written next cycle, preserving order.
- **Dropped results.** Results with we=0, and with rd=0/we=1 → accepted (ready=1), `rf_we_o` stays 0, count stays 0.
- **Pointer wrap.** Stream 10 results with `core_wb_we_i` alternating 1/0 → all 10 RF writes occur in acceptance order with matching data and ID; count never exceeds 2.
- **Reset mid-operation.** Fill the FIFO with 2 entries, assert `rst_i` for 1 cycle:
  - during reset: `rf_we_o=0`, ready=0;
  - after reset: count=0, `empty_o=1`, no stale writes appear.
